// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier job arbiter.
package mult_arb_pkg;

  localparam int OPW                = 8;
  localparam int PRW                = 16;
  localparam int TIMEOUT_CYCLES_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mult_job_arbiter_rr_arb2.sv
// Two-requester round-robin grant: a lone valid requester always wins,
// a tie goes to the requester selected by prio (0 = req0, 1 = req1).
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  // One-hot grant; the two terms are mutually exclusive by construction.
  always_comb begin
    grant = 2'b00;
    if (valid[0] && (!valid[1] || !prio)) grant[0] = 1'b1;
    if (valid[1] && (!valid[0] ||  prio)) grant[1] = 1'b1;
  end

endmodule

// File: rtl/mult_job_arbiter.sv
// Arbitrates two operand requesters onto a single 8x8 multiplier, one job
// in flight, and returns the product tagged with the owner's index.
// Optional WAIT timeout: define MULT_ARB_TIMEOUT_EN.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | grant a requester, capture its operands and index
//   ST_LAUNCH | one-cycle mult_start pulse
//   ST_WAIT   | operands held, waiting for mult_done (or timeout)
//   ST_RESP   | response presented until rsp_ready
module mult_job_arbiter
  import mult_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset_a,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_a,
  input  logic [OPW-1:0] req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_a,
  input  logic [OPW-1:0] req1_b,
  output logic           mult_start,
  output logic [OPW-1:0] mult_a,
  output logic [OPW-1:0] mult_b,
  input  logic           mult_done,
  input  logic [PRW-1:0] mult_product,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [PRW-1:0] rsp_product,
  output logic           rsp_err,
  output logic           busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t         state_q, state_d;
  logic           prio_q, prio_d;
  logic [OPW-1:0] mult_a_q, mult_a_d;
  logic [OPW-1:0] mult_b_q, mult_b_d;
  logic           rsp_id_q, rsp_id_d;
  logic [PRW-1:0] rsp_product_q, rsp_product_d;
  logic [1:0]     grant;
  logic           accept;
  logic           timeout_hit;

  rr_arb2 u_rr_arb2 (
    .valid ({req1_valid, req0_valid}),
    .prio  (prio_q),
    .grant (grant)
  );

  // reset_a gates ready so nothing is offered while reset is held.
  assign req0_ready  = grant[0] & (state_q == ST_IDLE) & reset_a;
  assign req1_ready  = grant[1] & (state_q == ST_IDLE) & reset_a;
  assign accept      = req0_ready | req1_ready;

  assign mult_start  = (state_q == ST_LAUNCH);
  assign rsp_valid   = (state_q == ST_RESP);
  assign busy        = (state_q != ST_IDLE);
  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_err_q, rsp_err_d;

  // Counts WAIT cycles; cleared in LAUNCH so it starts at zero on WAIT entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_LAUNCH)    cnt_d = '0;
    else if (state_q == ST_WAIT) cnt_d = cnt_q + CW'(1);
  end

  // Fires on the last allowed WAIT cycle; mult_done has priority in the FSM.
  assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Error flag follows the way WAIT was left.
  always_comb begin
    rsp_err_d = rsp_err_q;
    if (state_q == ST_WAIT) begin
      if (mult_done)        rsp_err_d = 1'b0;
      else if (timeout_hit) rsp_err_d = 1'b1;
    end
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // Next-state and datapath capture.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mult_a_d = grant[1] ? req1_a : req0_a;
          mult_b_d = grant[1] ? req1_b : req0_b;
          rsp_id_d = grant[1];
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mult_done) begin
          rsp_product_d = mult_product;
          state_d       = ST_RESP;
        end else if (timeout_hit) begin
          rsp_product_d = '0;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          prio_d  = ~rsp_id_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q       <= ST_IDLE;
      prio_q        <= 1'b0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      rsp_id_q      <= 1'b0;
      rsp_product_q <= '0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
    end
  end

endmodule

// File: doc/mult_job_arbiter.md
MULT_JOB_ARBITER -- requirements
Module: mult_job_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL be the maximum cycles allowed in WAIT before abort (used only with MULT_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_a  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester n has an operand pair pending.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester n's operands this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  8 each  unsigned operands of requester n.
REQ-007 mult_start  output  1  start pulse to the 8x8 multiplier controller.
REQ-008 mult_a, mult_b  output  8 each  registered operands driven to the multiplier datapath.
REQ-009 mult_done  input  1  multiplier calculation complete.
REQ-010 mult_product  input  16  multiplier result, valid while mult_done=1.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  consumer accepts the response.
REQ-013 rsp_id  output  1  requester index owning the response.
REQ-014 rsp_product  output  16  captured product.
REQ-015 rsp_err  output  1  response aborted by timeout.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT and RESP, with one job in flight at most.
REQ-018 In IDLE, the arbiter SHALL assert ready only to the grant winner, combinationally, and never to both requesters.
REQ-019 Arbitration SHALL be two-way round-robin: if both are valid, the requester pointed to by prio wins; if one is valid, it wins.
REQ-020 On valid&ready, the arbiter SHALL register the operands into mult_a/mult_b and the winner index into rsp_id, then go to LAUNCH.
REQ-021 LAUNCH SHALL drive mult_start=1 for exactly one cycle and then go to WAIT; mult_start SHALL be 0 in every other state.
REQ-022 WAIT SHALL hold mult_a/mult_b stable; on mult_done=1 it SHALL capture mult_product into rsp_product, clear rsp_err and go to RESP.
REQ-023 The block SHALL ignore mult_done outside WAIT.
REQ-024 RESP SHALL hold rsp_valid=1 and all rsp_* stable until rsp_ready=1; it SHALL then go to IDLE and set prio to the requester not in rsp_id.
REQ-025 Latency: handshake in cycle N gives mult_start in N+1; mult_done in cycle M gives rsp_valid in M+1.
REQ-026 Requests SHALL NOT be accepted in LAUNCH, WAIT or RESP (both ready=0), including when rsp_ready and a new valid coincide in RESP.
REQ-027 Unused or illegal state encodings SHALL return to IDLE on the next clock.

Reset
REQ-028 While reset_a=0, the block SHALL force state=IDLE, prio=req0, mult_start=0, mult_a=mult_b=0, rsp_valid=0, rsp_id=0, rsp_product=0, rsp_err=0, busy=0, req*_ready=0 and timeout counter=0.
REQ-029 Reset asserted mid-job SHALL discard the job without generating a response.

Configuration
REQ-030 With macro MULT_ARB_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-031 With MULT_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES without mult_done, the block SHALL go to RESP with rsp_err=1 and rsp_product=0.
REQ-032 With MULT_ARB_TIMEOUT_EN defined, if mult_done and timeout coincide, mult_done SHALL win.
REQ-033 Without MULT_ARB_TIMEOUT_EN, WAIT SHALL last until mult_done, rsp_err SHALL be constant 0 and no counter logic SHALL be present.

Structure
REQ-034 Shared package mult_arb_pkg SHALL hold the state typedef, OPW=8, PRW=16 and the default TIMEOUT_CYCLES constant.
REQ-035 Sub-module rr_arb2 SHALL implement the two-requester round-robin grant (inputs: valids, prio; outputs: one-hot grant).

Verification
REQ-036 Scenario: req0 valid with a=0x0F, b=0x0F; multiplier asserts done 4 cycles after start with 0x00E1 -> mult_start pulse 1 cycle; rsp_valid at done+1 with rsp_id=0, rsp_product=0x00E1, rsp_err=0.
REQ-037 Scenario: both requesters continuously valid, rsp_ready=1 -> grants alternate 0,1,0,1 across 4 jobs, and both ready are never high together.
REQ-038 Scenario: rsp_ready held 0 for 10 cycles in RESP, new req1 valid -> rsp_* stable, req1_ready=0 throughout; accepted only after return to IDLE.
REQ-039 Scenario: MULT_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=15, mult_done never asserted -> rsp_valid with rsp_err=1, rsp_product=0 after 15 WAIT cycles; done coinciding with the limit gives rsp_err=0.
REQ-040 Scenario: reset_a pulsed low during WAIT -> all outputs at reset values immediately, no response after release, next request served normally.
REQ-041 Scenario: stray mult_done pulse in IDLE -> no state change and no response.
